id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
- Decode stage of the pipelined RV32I core. Producer side of the ALU control interface.
- Takes a fetched instruction and PC, then generates ALU control (aluop, alusrc, inst30, funct3), the immediate, register indices and memory/writeback control.
- Registers all of it into a one-entry ID/EX pipeline register with a valid/ready handshake, stall and flush.
- Also keeps a saturating count of illegal instructions.

Parameters:
- XLEN, 32, data/PC width; equals `REG_DATA_WIDTH and `IMM_WIDTH.
- CNT_WIDTH, 8, width of illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr/pc valid from fetch.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- pc  in  XLEN  instruction address.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  ID/EX register holds an instruction.
- out_ready  in  1  EX accepts.
- out_pc  out  XLEN  registered pc.
- aluop  out  2  00 address-add, 01 branch compare, 10 R-type/shift, 11 I-type arithmetic.
- alusrc  out  1  1 selects immediate as operand 2.
- op1_pc  out  1  1 selects pc as operand 1 (AUIPC, JAL).
- inst30  out  1  ALU sub/sra select.
- funct3  out  `FUNCT3_WIDTH  instr[14:12].
- immediate  out  `IMM_WIDTH  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register indices.
- regwrite, memread, memwrite, memtoreg, branch, jump  out  1 each  control.
- illegal  out  1  instruction not decodable.
- illegal_count  out  CNT_WIDTH  saturating illegal counter.

Behaviour:
- Reset (async, rst=1): all outputs 0, including out_valid and illegal_count. Takes effect immediately, mid-transfer included. The held instruction is lost.
- Handshake:
  - in_ready = !out_valid | out_ready | flush.
  - Load occurs when in_valid & in_ready & !flush. Latency is 1 cycle: decoded fields appear on the edge after acceptance.
  - out_valid & !out_ready: all outputs held stable. in_ready=0.
  - Transfer to EX without a new load: out_valid falls to 0 next cycle.
- Flush: out_valid<=0 next edge. An instruction presented in the same cycle is consumed (in_ready=1) and discarded. Flush beats load and stall.
- Immediate formats:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],0}).
- Decode by opcode. Unlisted control bits are 0. inst30 is 0 unless stated.
  - 0110011 R: aluop 10, alusrc 0, inst30=instr[30], regwrite.
  - 0010011 funct3 001/101 (shift-imm): aluop 10, alusrc 1, imm I, inst30=instr[30], regwrite.
    - Legal only if instr[31:25]=0000000, or 0100000 with funct3=101.
  - 0010011 other funct3: aluop 11, alusrc 1, imm I, inst30 forced 0, regwrite.
  - 0000011 load: aluop 00, alusrc 1, imm I, memread, memtoreg, regwrite. funct3 must be in {000,001,010,100,101}.
  - 0100011 store: aluop 00, alusrc 1, imm S, memwrite. funct3 ≤ 010.
  - 1100011 branch: aluop 01, alusrc 0, imm B, branch. funct3 010/011 are illegal.
  - 1101111 JAL: aluop 00, op1_pc, alusrc 1, imm J, jump, regwrite.
  - 1100111 JALR: aluop 00, alusrc 1, imm I, jump, regwrite. funct3 must be 000.
  - 0110111 LUI: aluop 00, alusrc 1, imm U, rs1 forced 0, regwrite.
  - 0010111 AUIPC: aluop 00, op1_pc, alusrc 1, imm U, regwrite.
- Illegal instruction:
  - illegal=1; regwrite, memread, memwrite, branch, jump all 0; still passes with out_valid=1.
  - illegal_count += 1 on each load of an illegal instruction; saturates at 2^CNT_WIDTH−1.
  - No increment when the incoming instruction is flushed.
- rd=0 with regwrite=1 passes unchanged; the register file ignores x0 writes.

Decomposition:
- Opcode constants, aluop encodings (ALUOP_ADDR/BRANCH/RTYPE/ITYPE) and immediate-format enum go in riscv_def.v next to the existing widths.
- Sub-module imm_gen: combinational, takes instr and format select, returns `IMM_WIDTH immediate.
- The decoder logic and pipeline register stay in id_decode_stage.

Test Plan:
- add x3,x1,x2 (0x002081B3), in_valid=1, out_ready=1 → next cycle out_valid=1, aluop=10, alusrc=0, inst30=0, funct3=000, rs1=1, rs2=2, rd=3, regwrite=1.
- srai x5,x6,3 (0x40335293) → aluop=10, alusrc=1, inst30=1, funct3=101, immediate=0x00000403, rs1=6, rd=5.
- beq x1,x2,−8 (0xFE208CE3) → aluop=01, branch=1, immediate=0xFFFFFFF8, regwrite=0.
- Hold out_ready=0 with out_valid=1, present 0x00100093 → in_ready=0; outputs unchanged 3 cycles. Release → addi loaded the cycle after transfer, aluop=11, immediate=1.
- flush=1 together with in_valid=1 → in_ready=1; out_valid=0 next cycle; illegal_count unchanged even when instr=0xFFFFFFFF.
- Feed 0xFFFFFFFF ×300 → illegal=1, regwrite=memwrite=0, illegal_count stops at 255. Assert rst mid-stream → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/id_decode_stage_pkg.sv
// rtl/id_decode_stage_pkg.sv - RV32I decode definitions: widths, opcodes, aluop codes, immediate formats
//
// Shared by the decode stage, its immediate generator and the ID/EX interface.
// Contents: data/immediate/funct3 widths, base opcodes, aluop encodings,
// immediate-format select enum and the packed decoded-control record.

package id_decode_stage_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int IMM_WIDTH      = 32;
    localparam int FUNCT3_WIDTH   = 3;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       op1_pc;
        logic       inst30;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // Load widths that exist in RV32I: lb, lh, lw, lbu, lhu.
    function automatic logic load_funct3_ok(input logic [FUNCT3_WIDTH-1:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// rtl/id_decode_stage_if.sv - ID/EX handshake and ALU-control bundle
//
// master: decode stage (drives out_valid and all decoded fields, receives out_ready)
// slave : execute stage (drives out_ready, receives everything else)

interface id_decode_stage_if
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN = REG_DATA_WIDTH
);
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_pc;
    logic [1:0]              aluop;
    logic                    alusrc;
    logic                    op1_pc;
    logic                    inst30;
    logic [FUNCT3_WIDTH-1:0] funct3;
    logic [IMM_WIDTH-1:0]    immediate;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    regwrite;
    logic                    memread;
    logic                    memwrite;
    logic                    memtoreg;
    logic                    branch;
    logic                    jump;
    logic                    illegal;

    modport master (
        output out_valid, out_pc, aluop, alusrc, op1_pc, inst30, funct3, immediate,
               rs1, rs2, rd, regwrite, memread, memwrite, memtoreg, branch, jump, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, aluop, alusrc, op1_pc, inst30, funct3, immediate,
               rs1, rs2, rd, regwrite, memread, memwrite, memtoreg, branch, jump, illegal,
        output out_ready
    );

endinterface

// File: rtl/id_decode_stage_imm_gen.sv
// rtl/id_decode_stage_imm_gen.sv - combinational RV32I immediate generator
//
// Ports:
//   instr_hi in  instr[31:7] (the opcode bits play no part in immediate assembly)
//   fmt      in  immediate format select
//   imm      out sign-extended / upper immediate, zero for IMM_NONE

module id_decode_stage_imm_gen
    import id_decode_stage_pkg::*;
(
    input  logic [31:7]          instr_hi,
    input  imm_fmt_e             fmt,
    output logic [IMM_WIDTH-1:0] imm
);

    logic sign;
    assign sign = instr_hi[31];

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{sign}}, instr_hi[31:20]};
            IMM_S: imm = {{20{sign}}, instr_hi[31:25], instr_hi[11:7]};
            IMM_B: imm = {{19{sign}}, sign, instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
            IMM_U: imm = {instr_hi[31:12], 12'b0};
            IMM_J: imm = {{11{sign}}, sign, instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - RV32I decode stage with one-entry ID/EX register
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid       fetch presents instr/pc
//   in_ready       stage can accept this cycle
//   instr, pc      instruction word and its address
//   flush          kill held and incoming instruction
//   ex             ID/EX bundle (master side): out_valid/out_ready plus decoded fields
//   illegal_count  saturating count of loaded illegal instructions

module id_decode_stage
    import id_decode_stage_pkg::*;
#(
    parameter int XLEN      = REG_DATA_WIDTH,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [XLEN-1:0]      pc,
    input  logic                 flush,
    id_decode_stage_if.master    ex,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    logic [6:0]              opcode;
    logic [FUNCT3_WIDTH-1:0] f3;
    logic [6:0]              funct7;
    ctrl_t                   dec;
    imm_fmt_e                fmt;
    logic                    rs1_zero;
    logic                    legal;
    logic [IMM_WIDTH-1:0]    imm_w;
    logic                    load;

    logic                    valid_q;
    logic [XLEN-1:0]         pc_q;
    ctrl_t                   ctl_q;
    logic [FUNCT3_WIDTH-1:0] f3_q;
    logic [IMM_WIDTH-1:0]    imm_q;
    logic [4:0]              rs1_q;
    logic [4:0]              rs2_q;
    logic [4:0]              rd_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign funct7 = instr[31:25];

    id_decode_stage_imm_gen u_imm_gen (
        .instr_hi (instr[31:7]),
        .fmt      (fmt),
        .imm      (imm_w)
    );

    always_comb begin
        dec      = '0;
        fmt      = IMM_NONE;
        rs1_zero = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                dec.aluop    = ALUOP_RTYPE;
                dec.inst30   = instr[30];
                dec.regwrite = 1'b1;
            end
            OPC_OPIMM: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                fmt          = IMM_I;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediate reuses the R-type ALU path; instr[30] picks srai.
                    dec.aluop  = ALUOP_RTYPE;
                    dec.inst30 = instr[30];
                    legal      = (funct7 == 7'b0000000) ||
                                 (funct7 == 7'b0100000 && f3 == 3'b101);
                end else begin
                    // instr[30] is immediate data here, never a sub select.
                    dec.aluop = ALUOP_ITYPE;
                end
            end
            OPC_LOAD: begin
                dec.aluop    = ALUOP_ADDR;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                fmt          = IMM_I;
                legal        = load_funct3_ok(f3);
            end
            OPC_STORE: begin
                dec.aluop    = ALUOP_ADDR;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                fmt          = IMM_S;
                legal        = (f3 <= 3'b010);
            end
            OPC_BRANCH: begin
                dec.aluop  = ALUOP_BRANCH;
                dec.branch = 1'b1;
                fmt        = IMM_B;
                legal      = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_JAL: begin
                dec.aluop    = ALUOP_ADDR;
                dec.op1_pc   = 1'b1;
                dec.alusrc   = 1'b1;
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                fmt          = IMM_J;
            end
            OPC_JALR: begin
                dec.aluop    = ALUOP_ADDR;
                dec.alusrc   = 1'b1;
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                fmt          = IMM_I;
                legal        = (f3 == 3'b000);
            end
            OPC_LUI: begin
                // Executed as x0 + imm, so rs1 must read as zero.
                dec.aluop    = ALUOP_ADDR;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                rs1_zero     = 1'b1;
                fmt          = IMM_U;
            end
            OPC_AUIPC: begin
                dec.aluop    = ALUOP_ADDR;
                dec.op1_pc   = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                fmt          = IMM_U;
            end
            default: legal = 1'b0;
        endcase

        // An illegal instruction still travels down the pipe, but must not
        // change architectural state.
        if (!legal) begin
            dec.illegal  = 1'b1;
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.branch   = 1'b0;
            dec.jump     = 1'b0;
        end
    end

    // Flush keeps the stage accepting so a killed instruction is consumed.
    assign in_ready = !rst && (!valid_q || ex.out_ready || flush);
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ctl_q   <= '0;
            f3_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
                pc_q    <= pc;
                ctl_q   <= dec;
                f3_q    <= f3;
                imm_q   <= imm_w;
                rs1_q   <= rs1_zero ? 5'd0 : instr[19:15];
                rs2_q   <= instr[24:20];
                rd_q    <= instr[11:7];
            end else if (ex.out_ready) begin
                valid_q <= 1'b0;
            end

            if (load && dec.illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign ex.out_valid   = valid_q;
    assign ex.out_pc      = pc_q;
    assign ex.aluop       = ctl_q.aluop;
    assign ex.alusrc      = ctl_q.alusrc;
    assign ex.op1_pc      = ctl_q.op1_pc;
    assign ex.inst30      = ctl_q.inst30;
    assign ex.funct3      = f3_q;
    assign ex.immediate   = imm_q;
    assign ex.rs1         = rs1_q;
    assign ex.rs2         = rs2_q;
    assign ex.rd          = rd_q;
    assign ex.regwrite    = ctl_q.regwrite;
    assign ex.memread     = ctl_q.memread;
    assign ex.memwrite    = ctl_q.memwrite;
    assign ex.memtoreg    = ctl_q.memtoreg;
    assign ex.branch      = ctl_q.branch;
    assign ex.jump        = ctl_q.jump;
    assign ex.illegal     = ctl_q.illegal;
    assign illegal_count  = cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - directed table-driven bench for id_decode_stage

module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        in_ready;
    logic [7:0]  illegal_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_decode_stage_if #(.XLEN(32)) ex ();

    id_decode_stage #(.XLEN(32), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .flush         (flush),
        .ex            (ex),
        .illegal_count (illegal_count)
    );

    // ctl = {regwrite, memread, memwrite, memtoreg, branch, jump}
    typedef struct {
        logic [31:0] instr;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        op1_pc;
        logic        inst30;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  ctl;
        logic        illegal;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [31:0] i, input logic [1:0] op, input logic src,
                                input logic p1, input logic i30, input logic [2:0] f,
                                input logic [31:0] im, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic [5:0] c, input logic il);
        vec_t v;
        v.instr = i; v.aluop = op; v.alusrc = src; v.op1_pc = p1; v.inst30 = i30;
        v.f3 = f; v.imm = im; v.rs1 = a; v.rs2 = b; v.rd = d; v.ctl = c; v.illegal = il;
        return v;
    endfunction

    function automatic logic [95:0] act_pack();
        return {1'b0, ex.out_valid, ex.aluop, ex.alusrc, ex.op1_pc, ex.inst30, ex.funct3,
                ex.immediate, ex.rs1, ex.rs2, ex.rd, ex.regwrite, ex.memread, ex.memwrite,
                ex.memtoreg, ex.branch, ex.jump, ex.illegal, ex.out_pc};
    endfunction

    function automatic logic [95:0] exp_pack(input vec_t v, input logic vld, input logic [31:0] p);
        return {1'b0, vld, v.aluop, v.alusrc, v.op1_pc, v.inst30, v.f3, v.imm,
                v.rs1, v.rs2, v.rd, v.ctl, v.illegal, p};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;
    vec_t v_add, v_addi;

    initial begin
        ex.out_ready = 1'b0;

        vecs[0]  = mk(32'h002081B3, 2'b10, 0, 0, 0, 3'd0, 32'h00000000, 1,  2,  3,  6'b100000, 0);
        vecs[1]  = mk(32'h40335293, 2'b10, 1, 0, 1, 3'd5, 32'h00000403, 6,  3,  5,  6'b100000, 0);
        vecs[2]  = mk(32'hFE208CE3, 2'b01, 0, 0, 0, 3'd0, 32'hFFFFFFF8, 1,  2,  25, 6'b000010, 0);
        vecs[3]  = mk(32'h00100093, 2'b11, 1, 0, 0, 3'd0, 32'h00000001, 0,  1,  1,  6'b100000, 0);
        vecs[4]  = mk(32'hFFC12283, 2'b00, 1, 0, 0, 3'd2, 32'hFFFFFFFC, 2,  28, 5,  6'b110100, 0);
        vecs[5]  = mk(32'h0071A423, 2'b00, 1, 0, 0, 3'd2, 32'h00000008, 3,  7,  8,  6'b001000, 0);
        vecs[6]  = mk(32'h001000EF, 2'b00, 1, 1, 0, 3'd0, 32'h00000800, 0,  1,  1,  6'b100001, 0);
        vecs[7]  = mk(32'h00008067, 2'b00, 1, 0, 0, 3'd0, 32'h00000000, 1,  0,  0,  6'b100001, 0);
        vecs[8]  = mk(32'h12345537, 2'b00, 1, 0, 0, 3'd5, 32'h12345000, 0,  3,  10, 6'b100000, 0);
        vecs[9]  = mk(32'hFFFFF117, 2'b00, 1, 1, 0, 3'd7, 32'hFFFFF000, 31, 31, 2,  6'b100000, 0);
        vecs[10] = mk(32'h40628233, 2'b10, 0, 0, 1, 3'd0, 32'h00000000, 5,  6,  4,  6'b100000, 0);
        vecs[11] = mk(32'h40109093, 2'b10, 1, 0, 1, 3'd1, 32'h00000401, 1,  1,  1,  6'b000000, 1);
        vecs[12] = mk(32'h0020A063, 2'b01, 0, 0, 0, 3'd2, 32'h00000000, 1,  2,  0,  6'b000000, 1);
        vecs[13] = mk(32'hFFF0F093, 2'b11, 1, 0, 0, 3'd7, 32'hFFFFFFFF, 1,  31, 1,  6'b100000, 0);
        vecs[14] = mk(32'hFFFFFFFF, 2'b00, 0, 0, 0, 3'd7, 32'h00000000, 31, 31, 31, 6'b000000, 1);
        vecs[15] = mk(32'h0000B003, 2'b00, 1, 0, 0, 3'd3, 32'h00000000, 1,  0,  0,  6'b000100, 1);
        v_add  = vecs[0];
        v_addi = vecs[3];

        // Reset state, asserted before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_fields", act_pack(), 96'd0);
        check("reset_ready_count", {87'd0, in_ready, illegal_count}, 96'd0);
        tick();
        rst = 1'b0;

        // Back-to-back table, EX always ready.
        exp_cnt = 0;
        ex.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            instr = vecs[i].instr;
            pc = 32'h1000 + 32'(i) * 4;
            tick();
            if (vecs[i].illegal) exp_cnt++;
            check($sformatf("vec%0d_%h", i, vecs[i].instr), act_pack(), exp_pack(vecs[i], 1'b1, pc));
        end
        check("count_after_table", {88'd0, illegal_count}, 96'(exp_cnt));

        // Transfer with no new load empties the register.
        in_valid = 1'b0;
        tick();
        check("drain_valid", {95'd0, ex.out_valid}, 96'd0);

        // Stall: hold add while EX is not ready, addi waits.
        ex.out_ready = 1'b0;
        in_valid = 1'b1;
        instr = v_add.instr;
        pc = 32'h2000;
        tick();
        check("stall_load_add", act_pack(), exp_pack(v_add, 1'b1, 32'h2000));
        instr = v_addi.instr;
        pc = 32'h2004;
        #1;
        check("stall_in_ready", {95'd0, in_ready}, 96'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_hold%0d", c), act_pack(), exp_pack(v_add, 1'b1, 32'h2000));
        end
        ex.out_ready = 1'b1;
        #1;
        check("release_in_ready", {95'd0, in_ready}, 96'd1);
        tick();
        check("release_addi", act_pack(), exp_pack(v_addi, 1'b1, 32'h2004));

        // Flush with a held instruction and an illegal incoming one.
        ex.out_ready = 1'b0;
        flush = 1'b1;
        instr = 32'hFFFFFFFF;
        #1;
        check("flush_in_ready", {95'd0, in_ready}, 96'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {95'd0, ex.out_valid}, 96'd0);
        check("flush_count", {88'd0, illegal_count}, 96'(exp_cnt));

        // Illegal counter: exact increments, then saturation.
        ex.out_ready = 1'b1;
        in_valid = 1'b1;
        instr = 32'hFFFFFFFF;
        for (int k = 0; k < 10; k++) tick();
        check("count_plus10", {88'd0, illegal_count}, 96'(exp_cnt + 10));
        for (int k = 10; k < 300; k++) tick();
        check("count_saturated", {88'd0, illegal_count}, 96'd255);
        check("illegal_ctl", {91'd0, ex.out_valid, ex.illegal, ex.regwrite, ex.memwrite, ex.jump},
              {91'd0, 5'b11000});

        // Asynchronous reset mid-stream, checked before the next edge.
        #2 rst = 1'b1;
        #1;
        check("async_reset_fields", act_pack(), 96'd0);
        check("async_reset_ready_count", {87'd0, in_ready, illegal_count}, 96'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
